shift_serializer_ctrl: RTL

Framing controller that sequences a left-shifting (MSB-first) shift register as a full-duplex serializer/deserializer. It accepts parallel words over a valid/ready handshake and shifts each word out serially at a programmable bit rate. At the same time it captures serial_in into the vacated LSBs and presents the received word with a one-cycle valid strobe. It sits between a word-level producer/consumer and a bit-level serial link (SPI-like data lane).

---
 rtl/shift_serializer_ctrl.sv | 104 ++++++++++
 1 files changed

// File: rtl/shift_serializer_ctrl.sv
// rtl/shift_serializer_ctrl.sv - MSB-first full-duplex shift serializer/deserializer controller
// Words load in IDLE, shift one bit per (div_lat+1) cycles while serial_in fills the vacated LSBs.
module shift_serializer_ctrl #(
  parameter int WIDTH     = 8,
  parameter int DIV_WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [WIDTH-1:0]     tx_data,
  input  logic                 tx_valid,
  output logic                 tx_ready,
  input  logic [DIV_WIDTH-1:0] div_cfg,
  input  logic                 abort,
  input  logic                 serial_in,
  output logic                 serial_out,
  output logic                 bit_strobe,
  output logic                 busy,
  output logic [WIDTH-1:0]     rx_data,
  output logic                 rx_valid
);

  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t               state, state_nxt;
  logic [WIDTH-1:0]     shift_reg;
  logic [CW-1:0]        bit_cnt;
  logic [DIV_WIDTH-1:0] div_cnt;
  logic [DIV_WIDTH-1:0] div_lat;
  logic                 accept;
  logic                 word_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    tx_ready   = 1'b0;
    busy       = 1'b0;
    serial_out = 1'b0;
    bit_strobe = 1'b0;
    accept     = 1'b0;
    word_done  = 1'b0;
    case (state)
      IDLE: begin
        tx_ready = 1'b1;
        if (tx_valid) begin
          accept    = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        busy       = 1'b1;
        serial_out = shift_reg[WIDTH-1];
        bit_strobe = (div_cnt == div_lat);
        // abort wins even over the final strobe, so no word is delivered
        if (abort) begin
          state_nxt = IDLE;
        end else if (bit_strobe && bit_cnt == LAST_BIT) begin
          word_done = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
      div_cnt   <= '0;
      div_lat   <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
    end else begin
      rx_valid <= word_done;
      if (accept) begin
        shift_reg <= tx_data;
        div_lat   <= div_cfg;
        div_cnt   <= '0;
        bit_cnt   <= '0;
      end else if (state == SHIFT) begin
        if (abort) begin
          shift_reg <= '0;
          bit_cnt   <= '0;
          div_cnt   <= '0;
        end else if (bit_strobe) begin
          shift_reg <= {shift_reg[WIDTH-2:0], serial_in};
          div_cnt   <= '0;
          bit_cnt   <= word_done ? '0 : bit_cnt + 1'b1;
          if (word_done) rx_data <= {shift_reg[WIDTH-2:0], serial_in};
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule
